// File: rtl/fixed_point_division.sv
// ---------------------------------------------------------------------------
// fixed_point_division
//
// Sequential unsigned fixed-point divider, q = A / B, all values Q5.5
// (10 bits: 5 integer bits, 5 fraction bits). Operands are captured into
// holding registers by ld_a / ld_b. A start pulse in IDLE snapshots them
// into working registers. A restoring shift-subtract loop then produces one
// quotient bit per clock, 15 steps in total. The result and the overflow
// flag stay registered until the next completed division or a reset.
//
// Ports
//   clk    in   1   clock, all state updates on the rising edge
//   rst    in   1   synchronous, active-high reset (dominates everything)
//   start  in   1   launch a division (only looked at in IDLE)
//   ld_a   in   1   load A into the dividend holding register
//   ld_b   in   1   load B into the divisor holding register
//   A      in   10  dividend, unsigned Q5.5
//   B      in   10  divisor, unsigned Q5.5
//   q      out  10  quotient, unsigned Q5.5, truncated, saturates at 10'h3FF
//   ov     out  1   overflow / divide-by-zero flag
// ---------------------------------------------------------------------------
module fixed_point_division (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       ld_a,
    input  logic       ld_b,
    input  logic [9:0] A,
    input  logic [9:0] B,
    output logic [9:0] q,
    output logic       ov
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t      state;
    state_t      state_next;

    // Operand holding registers, loadable at any time
    logic [9:0]  ra;
    logic [9:0]  rb;

    // Working copies taken at launch, so later loads cannot disturb a run
    logic [9:0]  divisor;
    logic [14:0] dividend;
    logic [9:0]  remainder;
    logic [13:0] quot;
    logic [3:0]  cnt;

    // One restoring step, computed combinationally from the working regs
    logic [10:0] trial;
    logic [9:0]  rem_step;
    logic        q_bit;
    logic [14:0] quot_step;
    logic        last_step;
    logic        saturate;

    // The remainder is always below the divisor (at most 10'h3FF), so it
    // fits in 10 bits; only the trial value needs the extra MSB. When the
    // subtraction succeeds the true difference is below the divisor as
    // well, so the low 10 bits of the modular difference are exact.
    always_comb begin
        trial     = {remainder, dividend[14]};
        rem_step  = trial[9:0];
        q_bit     = 1'b0;
        if (trial >= {1'b0, divisor}) begin
            rem_step = trial[9:0] - divisor;
            q_bit    = 1'b1;
        end
        quot_step = {quot, q_bit};
        last_step = (cnt == 4'd14);
        saturate  = (divisor == 10'd0) || (quot_step[14:10] != 5'd0);
    end

    // Next-state logic: launch from IDLE on start, return after step 15
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start)     state_next = BUSY;
            BUSY: if (last_step) state_next = IDLE;
            default:             state_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Operand holding registers; a launch on the same edge as a load sees
    // the old contents because the snapshot reads ra/rb before they update
    always_ff @(posedge clk) begin
        if (rst) begin
            ra <= 10'd0;
            rb <= 10'd0;
        end else begin
            if (ld_a) ra <= A;
            if (ld_b) rb <= B;
        end
    end

    // Datapath: snapshot at launch, one shift-subtract step per BUSY clock,
    // outputs written only on the final step so they never change mid-run
    always_ff @(posedge clk) begin
        if (rst) begin
            divisor   <= 10'd0;
            dividend  <= 15'd0;
            remainder <= 10'd0;
            quot      <= 14'd0;
            cnt       <= 4'd0;
            q         <= 10'd0;
            ov        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        dividend  <= {ra, 5'b0};
                        divisor   <= rb;
                        remainder <= 10'd0;
                        quot      <= 14'd0;
                        cnt       <= 4'd0;
                    end
                end
                BUSY: begin
                    remainder <= rem_step;
                    dividend  <= {dividend[13:0], 1'b0};
                    quot      <= quot_step[13:0];
                    cnt       <= cnt + 4'd1;
                    if (last_step) begin
                        if (saturate) begin
                            q  <= 10'h3FF;
                            ov <= 1'b1;
                        end else begin
                            q  <= quot_step[9:0];
                            ov <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fixed_point_division.sv
// ---------------------------------------------------------------------------
// tb_fixed_point_division
//
// Self-checking bench for fixed_point_division. Expected results come from
// plain integer arithmetic on the Q5.5 values: floor(A*32/B), saturated to
// 10'h3FF with ov=1 on overflow or a zero divisor. A model of the operand
// holding registers tracks which A/B each launch actually uses.
// ---------------------------------------------------------------------------
module tb_fixed_point_division;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       ld_a;
    logic       ld_b;
    logic [9:0] A;
    logic [9:0] B;
    logic [9:0] q;
    logic       ov;

    int vectors     = 0;
    int miscompares = 0;

    // Model of the operand holding registers and of the held outputs
    logic [9:0] m_ra     = 10'd0;
    logic [9:0] m_rb     = 10'd0;
    logic [9:0] prev_q   = 10'd0;
    logic       prev_ov  = 1'b0;

    fixed_point_division dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .ld_a  (ld_a),
        .ld_b  (ld_b),
        .A     (A),
        .B     (B),
        .q     (q),
        .ov    (ov)
    );

    always #5 clk = ~clk;

    // Advance one rising edge; inputs are driven and outputs sampled 1ns later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference quotient from the arithmetic definition of Q5.5 division
    function automatic void model(input logic [9:0] a, input logic [9:0] b,
                                  output logic [9:0] eq, output logic eov);
        int unsigned quotient;
        if (b == 10'd0) begin
            eq  = 10'h3FF;
            eov = 1'b1;
        end else begin
            quotient = (int'(a) * 32) / int'(b);
            if (quotient > 1023) begin
                eq  = 10'h3FF;
                eov = 1'b1;
            end else begin
                eq  = quotient[9:0];
                eov = 1'b0;
            end
        end
    endfunction

    task automatic checkOutput(input string tag, input logic [9:0] eq, input logic eov);
        vectors++;
        assert (q === eq && ov === eov)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: got q=%h ov=%b, expected q=%h ov=%b", tag, q, ov, eq, eov);
        end
    endtask

    // Load both operand registers in one clock
    task automatic applyStimulus(input logic [9:0] a, input logic [9:0] b);
        ld_a = 1'b1;
        ld_b = 1'b1;
        A    = a;
        B    = b;
        tick();
        m_ra = a;
        m_rb = b;
        ld_a = 1'b0;
        ld_b = 1'b0;
    endtask

    // Launch one division and follow it to completion. During the run the
    // operand registers are reloaded with random values and (unless start
    // is held) a stray start pulse is given; neither may affect this result.
    // Optionally A is loaded on the launch edge itself, which must not be used.
    task automatic runAndCheck(input string tag, input bit sameEdgeLoad,
                               input logic [9:0] sameEdgeA, input bit holdStart);
        logic [9:0] eq;
        logic       eov;
        model(m_ra, m_rb, eq, eov);
        start = 1'b1;
        ld_a  = sameEdgeLoad;
        A     = sameEdgeA;
        tick();
        if (sameEdgeLoad) m_ra = sameEdgeA;
        ld_a = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            start = holdStart ? 1'b1 : (i == 6);
            ld_a  = (i == 3);
            ld_b  = (i == 3);
            if (i == 3) begin
                A = 10'($urandom_range(0, 1023));
                B = 10'($urandom_range(0, 1023));
            end
            tick();
            if (i == 3) begin
                m_ra = A;
                m_rb = B;
            end
            if (i < 15) checkOutput({tag, "_busy_hold"}, prev_q, prev_ov);
            else        checkOutput(tag, eq, eov);
        end
        ld_a    = 1'b0;
        ld_b    = 1'b0;
        start   = holdStart;
        prev_q  = eq;
        prev_ov = eov;
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        ld_a  = 1'b0;
        ld_b  = 1'b0;
        A     = 10'd0;
        B     = 10'd0;
        tick();
        rst = 1'b0;
        checkOutput("reset", 10'd0, 1'b0);

        // Operands loaded but no start: outputs must stay cleared
        ld_a = 1'b1;
        ld_b = 1'b1;
        A    = 10'h020;
        B    = 10'h010;
        for (int i = 0; i < 7; i++) begin
            tick();
            checkOutput("idle_no_start", 10'd0, 1'b0);
        end
        m_ra = 10'h020;
        m_rb = 10'h010;
        ld_a = 1'b0;
        ld_b = 1'b0;

        // 1.0 / 0.5 = 2.0
        runAndCheck("one_over_half", 1'b0, 10'd0, 1'b0);
        checkOutput("one_over_half_const", 10'h040, 1'b0);

        // 1.0 / 3.0 truncates to 0.3125
        applyStimulus(10'h020, 10'h060);
        runAndCheck("one_over_three", 1'b0, 10'd0, 1'b0);
        checkOutput("one_over_three_const", 10'h00A, 1'b0);

        // Largest over smallest overflows
        applyStimulus(10'h3FF, 10'h001);
        runAndCheck("overflow", 1'b0, 10'd0, 1'b0);
        checkOutput("overflow_const", 10'h3FF, 1'b1);

        // Divide by zero
        applyStimulus(10'h020, 10'h000);
        runAndCheck("div_zero", 1'b0, 10'd0, 1'b0);

        // Reset on the 8th edge of a run aborts it and clears everything
        applyStimulus(10'h020, 10'h010);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i < 8; i++) tick();
        rst = 1'b1;
        tick();
        rst     = 1'b0;
        m_ra    = 10'd0;
        m_rb    = 10'd0;
        prev_q  = 10'd0;
        prev_ov = 1'b0;
        checkOutput("abort", 10'd0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput("abort_quiet", 10'd0, 1'b0);
        end

        // Operand registers were cleared by reset: this is a divide by zero
        runAndCheck("cleared_operands", 1'b0, 10'd0, 1'b0);

        // Restart with new operands: 5.0 / 1.5 = 3.3125 truncated
        applyStimulus(10'h0A0, 10'h030);
        runAndCheck("restart", 1'b0, 10'd0, 1'b0);
        checkOutput("restart_const", 10'h06A, 1'b0);

        // A loaded on the launch edge must not be used by that launch
        applyStimulus(10'h040, 10'h020);
        runAndCheck("same_edge_load", 1'b1, 10'h3FF, 1'b0);

        // Start held high relaunches as soon as IDLE is reached
        applyStimulus(10'h020, 10'h020);
        runAndCheck("held_start_1", 1'b0, 10'd0, 1'b1);
        runAndCheck("held_start_2", 1'b0, 10'd0, 1'b0);
        start = 1'b0;

        // Random operands, small divisors favoured to hit overflow and zero
        for (int n = 0; n < 25; n++) begin
            logic [9:0] ra;
            logic [9:0] rb;
            ra = 10'($urandom_range(0, 1023));
            if ($urandom_range(0, 3) == 0) rb = 10'($urandom_range(0, 15));
            else                           rb = 10'($urandom_range(0, 1023));
            applyStimulus(ra, rb);
            runAndCheck("random", 1'b0, 10'd0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
